frac_neuron_relu: RTL and testbench

- Single serial neuron: accumulates BIAS plus N_INPUTS products of sign-magnitude fractional inputs and fixed weights, then applies ReLU.
- Built from three combinational parts: fraction multiplier, sign-magnitude adder, ReLU.
- Sits in a layer of the hardware NN datapath. It is fed one input sample per accepted cycle and emits one 23-bit activation per input vector.

---
 rtl/frac_nn_pkg.sv | 56 +++++
 rtl/frac_sm_adder.sv | 15 +
 rtl/frac_neuron_relu.sv | 99 +++++++++
 tb/tb_frac_neuron_relu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/frac_nn_pkg.sv
// Shared types and arithmetic helpers for the fractional sign-magnitude neuron datapath.
// Optional build macro FRAC_NEURON_RELU_EN (used by frac_neuron_relu) selects the ReLU activation.
package frac_nn_pkg;

    localparam int IN_W      = 12;
    localparam int ACC_W     = 23;
    localparam int MAG_IN_W  = 11;
    localparam int MAG_ACC_W = 22;
    localparam logic [MAG_ACC_W-1:0] SAT_MAG = 22'h3FFFFF;

    // Sample / weight: sign bit plus Q0.11 magnitude
    typedef struct packed {
        logic                sign;
        logic [MAG_IN_W-1:0] mag;
    } in_sm_t;

    // Accumulator / activation: sign bit plus Q0.22 magnitude
    typedef struct packed {
        logic                 sign;
        logic [MAG_ACC_W-1:0] mag;
    } acc_sm_t;

    // Exact Q0.11 x Q0.11 -> Q0.22 product; a zero magnitude is always +0
    function automatic acc_sm_t frac_mul(input in_sm_t a, input in_sm_t b);
        acc_sm_t r;
        r.mag  = MAG_ACC_W'(a.mag) * MAG_ACC_W'(b.mag);
        r.sign = (r.mag != '0) ? (a.sign ^ b.sign) : 1'b0;
        return r;
    endfunction

    // Saturating sign-magnitude add; cancellation yields +0, never -0
    function automatic acc_sm_t sm_add(input acc_sm_t a, input acc_sm_t b);
        acc_sm_t            r;
        logic [MAG_ACC_W:0] s;
        r = '0;
        s = '0;
        if (a.sign == b.sign) begin
            s      = {1'b0, a.mag} + {1'b0, b.mag};
            r.mag  = s[MAG_ACC_W] ? SAT_MAG : s[MAG_ACC_W-1:0];
            r.sign = (r.mag != '0) ? a.sign : 1'b0;
        end else if (a.mag > b.mag) begin
            r.mag  = a.mag - b.mag;
            r.sign = a.sign;
        end else if (b.mag > a.mag) begin
            r.mag  = b.mag - a.mag;
            r.sign = b.sign;
        end
        return r;
    endfunction

    // Negative values clamp to +0, non-negative values pass through
    function automatic acc_sm_t relu(input acc_sm_t a);
        return a.sign ? acc_sm_t'('0) : a;
    endfunction

endpackage

// File: rtl/frac_sm_adder.sv
// Combinational 23-bit sign-magnitude saturating adder, shared by accumulator blocks.
module frac_sm_adder
    import frac_nn_pkg::*;
(
    input  acc_sm_t a,
    input  acc_sm_t b,
    output acc_sm_t sum
);

    // Single sign-magnitude add with saturation and +0 on cancellation
    always_comb begin
        sum = sm_add(a, b);
    end

endmodule

// File: rtl/frac_neuron_relu.sv
// Serial neuron: acc = BIAS + sum(in[k] * w[k]) over N_INPUTS accepted samples,
// then one activation pulse. Build macro FRAC_NEURON_RELU_EN selects ReLU;
// without it the raw saturated sum is emitted (linear activation).
module frac_neuron_relu
    import frac_nn_pkg::*;
#(
    parameter int                      N_INPUTS = 3,
    parameter logic [N_INPUTS*12-1:0]  WEIGHTS  = '0,
    parameter logic [22:0]             BIAS     = 23'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    output logic        out_valid,
    output logic [22:0] out_data
);

    localparam int IDX_W = $clog2(N_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    acc_sm_t          acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    acc_sm_t          out_data_q, out_data_d;

    in_sm_t           weight;
    acc_sm_t          product;
    acc_sm_t          sum;
    acc_sm_t          act;

    // Select the weight for the current sample index
    always_comb begin
        weight = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                weight = in_sm_t'(WEIGHTS[IN_W*k +: IN_W]);
            end
        end
    end

    // Product of the incoming sample and its weight
    always_comb begin
        product = frac_mul(in_sm_t'(in_data), weight);
    end

    frac_sm_adder u_adder (
        .a   (acc_q),
        .b   (product),
        .sum (sum)
    );

    // Activation applied to the completed sum
    always_comb begin
`ifdef FRAC_NEURON_RELU_EN
        act = relu(sum);
`else
        act = sum;
`endif
    end

    // Next-state: accumulate, or emit and restart on the last sample
    always_comb begin
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        if (in_valid) begin
            if (idx_q == LAST_IDX) begin
                out_data_d  = act;
                out_valid_d = 1'b1;
                acc_d       = acc_sm_t'(BIAS);
                idx_d       = '0;
            end else begin
                acc_d = sum;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // State registers; reset restarts the vector from the bias
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            acc_q       <= acc_sm_t'(BIAS);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_frac_neuron_relu.sv
// Directed bench for frac_neuron_relu; expectations follow FRAC_NEURON_RELU_EN.
module tb_frac_neuron_relu;

`ifdef FRAC_NEURON_RELU_EN
    localparam logic [22:0] NEG_EXP = 23'h000000;
`else
    localparam logic [22:0] NEG_EXP = 23'h700000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        sum_v = 1'b0, sat_v = 1'b0, can_v = 1'b0;
    logic [11:0] sum_d = '0, sat_d = '0, can_d = '0;
    logic        sum_ov, sat_ov, can_ov;
    logic [22:0] sum_od, sat_od, can_od;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    frac_neuron_relu #(
        .N_INPUTS(3), .WEIGHTS({3{12'h400}}), .BIAS(23'h0)
    ) u_sum (
        .clk(clk), .rst_n(rst_n), .in_valid(sum_v), .in_data(sum_d),
        .out_valid(sum_ov), .out_data(sum_od)
    );

    frac_neuron_relu #(
        .N_INPUTS(3), .WEIGHTS({3{12'h7FF}}), .BIAS(23'h3FFFFF)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(sat_v), .in_data(sat_d),
        .out_valid(sat_ov), .out_data(sat_od)
    );

    frac_neuron_relu #(
        .N_INPUTS(3), .WEIGHTS({12'h000, 12'h000, 12'h400}), .BIAS(23'h100000)
    ) u_can (
        .clk(clk), .rst_n(rst_n), .in_valid(can_v), .in_data(can_d),
        .out_valid(can_ov), .out_data(can_od)
    );

    // Drive one cycle of input into the chosen instance (0=sum,1=sat,2=cancel), return at next negedge
    task automatic drive(input int which, input logic v, input logic [11:0] d);
        sum_v = 1'b0; sat_v = 1'b0; can_v = 1'b0;
        case (which)
            0: begin sum_v = v; sum_d = d; end
            1: begin sat_v = v; sat_d = d; end
            default: begin can_v = v; can_d = d; end
        endcase
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        applied++;
        if (sum_ov !== 1'b0 || sat_ov !== 1'b0 || can_ov !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b%b%b expected 000", sum_ov, sat_ov, can_ov);
        end
        applied++;
        if (sum_od !== 23'h0 || sat_od !== 23'h0 || can_od !== 23'h0) begin
            miscompares++;
            $display("FAIL reset_out_data: got %h/%h/%h expected 0", sum_od, sat_od, can_od);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_negative;
        drive(0, 1'b1, 12'hC00);
        drive(0, 1'b1, 12'hC00);
        applied++;
        if (sum_ov !== 1'b0) begin
            miscompares++;
            $display("FAIL neg_early_valid: got %b expected 0", sum_ov);
        end
        drive(0, 1'b1, 12'hC00);
        applied++;
        if (sum_ov !== 1'b1 || sum_od !== NEG_EXP) begin
            miscompares++;
            $display("FAIL neg_result: got v=%b d=%h expected v=1 d=%h", sum_ov, sum_od, NEG_EXP);
        end
        drive(0, 1'b0, 12'h000);
    endtask

    task automatic test_sum;
        drive(0, 1'b1, 12'h400);
        drive(0, 1'b1, 12'h400);
        applied++;
        if (sum_ov !== 1'b0) begin
            miscompares++;
            $display("FAIL sum_early_valid: got %b expected 0", sum_ov);
        end
        drive(0, 1'b1, 12'h400);
        applied++;
        if (sum_ov !== 1'b1 || sum_od !== 23'h300000) begin
            miscompares++;
            $display("FAIL sum_result: got v=%b d=%h expected v=1 d=300000", sum_ov, sum_od);
        end
        drive(0, 1'b0, 12'h000);
        applied++;
        if (sum_ov !== 1'b0 || sum_od !== 23'h300000) begin
            miscompares++;
            $display("FAIL sum_hold: got v=%b d=%h expected v=0 d=300000", sum_ov, sum_od);
        end
    endtask

    task automatic test_reset_gaps;
        drive(0, 1'b1, 12'h400);
        drive(0, 1'b1, 12'h400);
        #2 rst_n = 1'b0;
        #1;
        applied++;
        if (sum_ov !== 1'b0 || sum_od !== 23'h0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got v=%b d=%h expected v=0 d=0", sum_ov, sum_od);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 12'h400);
        applied++;
        if (sum_ov !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_valid_1: got %b expected 0", sum_ov);
        end
        drive(0, 1'b0, 12'h000);
        drive(0, 1'b1, 12'h400);
        drive(0, 1'b0, 12'h000);
        drive(0, 1'b0, 12'h000);
        applied++;
        if (sum_ov !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_valid_2: got %b expected 0", sum_ov);
        end
        drive(0, 1'b1, 12'h400);
        applied++;
        if (sum_ov !== 1'b1 || sum_od !== 23'h300000) begin
            miscompares++;
            $display("FAIL gap_result: got v=%b d=%h expected v=1 d=300000", sum_ov, sum_od);
        end
        drive(0, 1'b0, 12'h000);
        applied++;
        if (sum_ov !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_single_pulse: got %b expected 0", sum_ov);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 3; i++) drive(1, 1'b1, 12'h7FF);
        applied++;
        if (sat_ov !== 1'b1 || sat_od !== 23'h3FFFFF) begin
            miscompares++;
            $display("FAIL saturation: got v=%b d=%h expected v=1 d=3fffff", sat_ov, sat_od);
        end
        drive(1, 1'b0, 12'h000);
    endtask

    task automatic test_cancel;
        drive(2, 1'b1, 12'hC00);
        drive(2, 1'b1, 12'h123);
        drive(2, 1'b1, 12'h456);
        applied++;
        if (can_ov !== 1'b1 || can_od !== 23'h000000) begin
            miscompares++;
            $display("FAIL cancel_pos_zero: got v=%b d=%h expected v=1 d=000000", can_ov, can_od);
        end
        drive(2, 1'b0, 12'h000);
    endtask

    task automatic test_back_to_back;
        logic [11:0] vec [6];
        logic        exp_v;
        logic [22:0] exp_d;
        vec = '{12'h400, 12'h400, 12'h400, 12'hC00, 12'hC00, 12'hC00};
        for (int i = 0; i < 9; i++) begin
            if (i < 6) drive(0, 1'b1, vec[i]);
            else       drive(0, 1'b0, 12'h000);
            exp_v = (i == 2) || (i == 5);
            exp_d = (i < 5) ? 23'h300000 : NEG_EXP;
            applied++;
            if (sum_ov !== exp_v || (exp_v && sum_od !== exp_d)) begin
                miscompares++;
                $display("FAIL b2b_step%0d: got v=%b d=%h expected v=%b d=%h",
                         i, sum_ov, sum_od, exp_v, exp_d);
            end
        end
    endtask

    initial begin
        test_reset;
        test_negative;
        test_sum;
        test_reset_gaps;
        test_saturation;
        test_cancel;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
